// File: rtl/rr_grant_pkg.sv
// Shared types and the circular priority search for the 8-way round-robin grant controller.
// Used by rr_grant_ctrl; optional hold timeout is enabled with RR_GRANT_HOLD_TIMEOUT_EN.
package rr_grant_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // Scan from the far end back to ptr so the bit nearest ptr is the last writer.
   function automatic pick_t rr_pick(
      input logic [N_REQ-1:0] req,
      input logic [IDX_W-1:0] ptr
   );
      pick_t            p;
      logic [IDX_W-1:0] k;
      p = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         k = ptr + IDX_W'(i);
         if (req[k]) begin
            p.found = 1'b1;
            p.idx   = k;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/onehot_dec3.sv
// Enable-gated 3-to-8 one-hot decoder.
// All-zero output while en is low.
module onehot_dec3
   import rr_grant_pkg::*;
(
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter / grant sequencer for one 8-way shared resource.
// Define RR_GRANT_HOLD_TIMEOUT_EN to force-release grants after MAX_HOLD cycles.
module rr_grant_ctrl
   import rr_grant_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   generate
      if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
         $error("rr_grant_ctrl: MAX_HOLD must lie in 2..256");
      end
   endgenerate

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_rel;
   logic [IDX_W-1:0] from;
   logic [N_REQ-1:0] pool;
   logic             held;
   logic             timeout;
   logic             rel;
   logic             load;
   pick_t            pick;

   assign held    = req[gnt_idx];
   assign rel     = (state == GRANT) && (!held || timeout);
   assign ptr_rel = gnt_idx + IDX_W'(1);
   assign from    = (state == GRANT) ? ptr_rel : ptr;

   // The outgoing winner sits out the re-arbitration it triggers.
   assign pool = rel ? (req & ~(N_REQ'(1) << gnt_idx)) : req;
   assign pick = rr_pick(pool, from);
   assign load = en && pick.found && ((state == IDLE) || rel);

`ifdef RR_GRANT_HOLD_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD);

   logic [HOLD_W-1:0] hold_cnt;

   assign timeout = held && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         preempt  <= 1'b0;
      end else begin
         preempt <= en && rel && timeout;
         if (load) begin
            hold_cnt <= '0;
         end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end
   end
`else
   assign timeout = 1'b0;
   assign preempt = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
      end else if (!en) begin
         if (state == GRANT) begin
            ptr <= ptr_rel;
         end
         state     <= IDLE;
         gnt_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick.found) begin
                  gnt_idx   <= pick.idx;
                  gnt_valid <= 1'b1;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (rel) begin
                  ptr <= ptr_rel;
                  if (pick.found) begin
                     gnt_idx <= pick.idx;
                  end else begin
                     gnt_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               gnt_valid <= 1'b0;
            end
         endcase
      end
   end

   onehot_dec3 u_dec (
      .en     (gnt_valid),
      .idx    (gnt_idx),
      .onehot (gnt)
   );

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: randomized and directed stimulus vs. a reference model.
// Define RR_GRANT_HOLD_TIMEOUT_EN to build and check the hold-timeout variant.
module tb_rr_grant_ctrl;

`ifdef RR_GRANT_HOLD_TIMEOUT_EN
   localparam int TB_HOLD = 4;
   localparam bit TMO     = 1'b1;
`else
   localparam int TB_HOLD = 16;
   localparam bit TMO     = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic       preempt;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // model state: owner of the resource (-1 none), rotation pointer, cycles owned
   int m_owner = -1;
   int m_ptr   = 0;
   int m_held  = 0;

   rr_grant_ctrl #(.MAX_HOLD(TB_HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int first_from(input logic [7:0] r, input int start);
      for (int k = 0; k < 8; k++) begin
         if (r[(start + k) % 8]) return (start + k) % 8;
      end
      return -1;
   endfunction

   // reference model: advance one clock edge, push the expected outputs
   initial begin
      exp_t e;
      logic [7:0] m;
      bit         pre;
      forever begin
         @(posedge clk);
         pre = 1'b0;
         if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
         end else if (!en) begin
            if (m_owner >= 0) m_ptr = (m_owner + 1) % 8;
            m_owner = -1;
         end else if (m_owner < 0) begin
            m_owner = first_from(req, m_ptr);
            m_held  = 1;
         end else if (!req[m_owner] || (TMO && m_held == TB_HOLD)) begin
            pre     = req[m_owner];
            m_ptr   = (m_owner + 1) % 8;
            m       = req;
            m[m_owner] = 1'b0;
            m_owner = first_from(m, m_ptr);
            m_held  = 1;
         end else begin
            m_held++;
         end
         e.valid   = (m_owner >= 0);
         e.idx     = e.valid ? 3'(m_owner) : 3'd0;
         e.gnt     = e.valid ? (8'h01 << m_owner) : 8'h00;
         e.preempt = pre;
         sb.push_back(e);
      end
   end

   // monitor: compare one expectation per clock, away from the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            chk("sb_empty", 8'd0, 8'd1);
         end else begin
            e = sb.pop_front();
            chk("gnt", gnt, e.gnt);
            chk("gnt_valid", {7'd0, gnt_valid}, {7'd0, e.valid});
            chk("preempt", {7'd0, preempt}, {7'd0, e.preempt});
            if (e.valid) chk("gnt_idx", {5'd0, gnt_idx}, {5'd0, e.idx});
         end
      end
   end

   task automatic drive(input logic e, input logic [7:0] r, input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         en  = e;
         req = r;
      end
   endtask

   // assert reset between edges and check the outputs clear without a clock
   task automatic async_reset(input bool_chk = 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      if (bool_chk) begin
         chk("rst_gnt", gnt, 8'h00);
         chk("rst_valid", {7'd0, gnt_valid}, 8'h00);
         chk("rst_idx", {5'd0, gnt_idx}, 8'h00);
         chk("rst_preempt", {7'd0, preempt}, 8'h00);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic [7:0]  rq;
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 8'hFF;
      #1;
      chk("init_gnt", gnt, 8'h00);
      chk("init_valid", {7'd0, gnt_valid}, 8'h00);
      chk("init_idx", {5'd0, gnt_idx}, 8'h00);
      chk("init_preempt", {7'd0, preempt}, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 8'hFF, 2);
      drive(1'b1, 8'hFF, 3);
      drive(1'b1, 8'hFE, 2);
      drive(1'b1, 8'hFC, 2);

      async_reset();
      drive(1'b1, 8'h81, 2);
      drive(1'b1, 8'h80, 2);
      drive(1'b1, 8'h01, 2);
      drive(1'b1, 8'h00, 2);

      drive(1'b1, 8'h08, 1);
      drive(1'b1, 8'hFF, 40);
      drive(1'b1, 8'h00, 2);

      async_reset(0);
      drive(1'b1, 8'h09, 14);
      drive(1'b1, 8'h00, 2);

      drive(1'b1, 8'h20, 1);
      drive(1'b1, 8'hFF, 2);
      drive(1'b0, 8'hFF, 2);
      drive(1'b1, 8'h20, 3);
      drive(1'b1, 8'hFF, 2);
      async_reset();

      drive(1'b1, 8'hFF, 2);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         req = ~(8'h01 << gnt_idx);
         drive(1'b1, 8'hFF, 1);
      end

      rq = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom;
         if (r[31:23] == 9'd0) begin
            async_reset();
         end else begin
            if (r[11:10] == 2'd0) rq = 8'($urandom);
            if (r[14:12] == 3'd0) rq = 8'h00;
            drive(r[7:4] != 4'd0, rq, 1);
         end
      end

      drive(1'b1, 8'h00, 3);
      @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
